// File: rtl/lcg_pkg.sv
// Shared constants and FSM encoding for the LCG generator and checker.
// Both sides import this so seed and recurrence always agree.
package lcg_pkg;

    localparam logic [15:0] LCG_X0 = 16'd2633;
    localparam logic [15:0] LCG_A  = 16'd3;
    localparam logic [15:0] LCG_B  = 16'd3;

    localparam logic [11:0] NO_ERR_IDX = 12'hFFF;
    localparam logic [11:0] ERR_MAX    = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/lcg_checker_if.sv
// Handshake and result bundle around the LCG checker.
// master = stimulus/producer side, slave = checker side.
interface lcg_checker_if;

    logic        start;
    logic [11:0] number;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        sum_valid;
    logic [15:0] sum_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [11:0] err_count;
    logic [11:0] first_err_idx;

    modport master (
        output start, number, in_valid, in_data, sum_valid, sum_in,
        input  in_ready, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        input  start, number, in_valid, in_data, sum_valid, sum_in,
        output in_ready, busy, done, pass, err_count, first_err_idx
    );

endinterface

// File: rtl/lcg_step.sv
// One LCG step: y = A*x + B mod 2^16.
// The multiply is a constant shift-add over the set bits of A.
module lcg_step
    import lcg_pkg::*;
#(
    parameter logic [15:0] A = LCG_A,
    parameter logic [15:0] B = LCG_B
) (
    input  logic [15:0] x,
    output logic [15:0] y
);

    logic [15:0] acc;

    // Sum shifted copies of x for each set bit of A, then add B.
    always_comb begin
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (A[i]) begin
                acc = acc + (x << i);
            end
        end
        y = acc + B;
    end

endmodule

// File: rtl/lcg_checker.sv
// Checks an incoming LCG term stream and its reported sum against
// a locally generated reference sequence.
module lcg_checker
    import lcg_pkg::*;
#(
    parameter logic [15:0] X0 = LCG_X0,
    parameter logic [15:0] A  = LCG_A,
    parameter logic [15:0] B  = LCG_B
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [11:0] number,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        sum_valid,
    input  logic [15:0] sum_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] err_count,
    output logic [11:0] first_err_idx
);

    state_t      state;
    state_t      state_nx;
    logic [11:0] n;
    logic [11:0] idx;
    logic [15:0] exp_val;
    logic [15:0] exp_next;
    logic [15:0] exp_sum;
    logic        go;
    logic        accept;
    logic        last;

    assign go     = start && (state == IDLE || state == DONE);
    assign accept = in_valid && (state == RUN);
    assign last   = (idx == n - 12'd1);

    lcg_step #(.A(A), .B(B)) u_step (
        .x (exp_val),
        .y (exp_next)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (number == 12'd0) ? SUM : RUN;
                end
            end
            RUN: begin
                if (accept && last) begin
                    state_nx = SUM;
                end
            end
            SUM: begin
                if (sum_valid) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state == RUN) || (state == SUM);
        done     = (state == DONE);
    end

    // Reference sequence, running sum and error bookkeeping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n             <= '0;
            idx           <= '0;
            exp_val       <= X0;
            exp_sum       <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
            pass          <= 1'b0;
        end else if (go) begin
            n             <= number;
            idx           <= '0;
            exp_val       <= X0;
            exp_sum       <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
            pass          <= 1'b0;
        end else if (accept) begin
            // Reference advances from its own value, never from in_data.
            exp_val <= exp_next;
            exp_sum <= exp_sum + exp_val;
            idx     <= idx + 12'd1;
            if (in_data != exp_val) begin
                if (err_count != ERR_MAX) begin
                    err_count <= err_count + 12'd1;
                end
                if (first_err_idx == NO_ERR_IDX) begin
                    first_err_idx <= idx;
                end
            end
        end else if (state == SUM && sum_valid) begin
            pass <= (sum_in == exp_sum) && (err_count == 12'd0);
        end
    end

endmodule

// File: doc/lcg_checker.md
LCG_CHECKER -- requirements
Module: lcg_checker

Interface
REQ-001 Parameter X0, default 2633: seed, the expected first term.
REQ-002 Parameter A, default 3: recurrence multiplier.
REQ-003 Parameter B, default 3: recurrence increment.
REQ-004 The block SHALL have exactly these ports:
- CLK  in  1: single clock, rising edge.
- RST_N  in  1: reset, asynchronous, active-low.
- start  in  1: begin a check run; sampled in IDLE or DONE.
- number  in  12: term count N, latched on an accepted start.
- in_valid  in  1: in_data is valid.
- in_data  in  16: received LCG term.
- in_ready  out  1: checker accepts a term.
- sum_valid  in  1: sum_in is valid.
- sum_in  in  16: producer's reported sum.
- busy  out  1: run in progress.
- done  out  1: result is valid.
- pass  out  1: all terms and the sum matched.
- err_count  out  12: number of term mismatches.
- first_err_idx  out  12: index of the first mismatching term.

Function
REQ-005 The FSM SHALL have states IDLE, RUN, SUM, DONE.
REQ-006 In IDLE or DONE, start=1 SHALL do all of the following:
- latch number;
- set exp=X0, exp_sum=0, idx=0, err_count=0, first_err_idx=12'hFFF, pass=0, done=0;
- move to RUN, or to SUM if N=0.
REQ-007 start SHALL be ignored in RUN and SUM.
REQ-008 in_ready SHALL equal (state==RUN), combinationally.
REQ-009 A term SHALL be accepted only on in_valid & in_ready; in_valid low SHALL stall the run with no state change.
REQ-010 On each accepted term, the checker SHALL compare in_data to exp. On mismatch:
- err_count increments, saturating at 4095;
- first_err_idx takes idx if it still holds 12'hFFF.
REQ-011 On each accepted term, the updates SHALL be:
- exp_sum <= exp_sum + exp, mod 2^16;
- exp <= A*exp + B, mod 2^16, computed from the expected value and never from in_data (no resync);
- idx increments.
REQ-012 The A*exp product SHALL be formed with shift-add logic only, truncated to 16 bits.
REQ-013 On acceptance of the term with idx==N-1, the FSM SHALL move to SUM on the next edge.
REQ-014 In SUM, the checker SHALL wait indefinitely for sum_valid. On sum_valid:
- pass <= (sum_in==exp_sum) && (err_count==0), counting a mismatch on the final term;
- move to DONE.
REQ-015 In DONE, done SHALL be 1 and pass, err_count and first_err_idx SHALL be held until the next start.
REQ-016 busy SHALL be 1 in RUN and SUM, 0 otherwise.
REQ-017 sum_valid SHALL be ignored outside SUM; in_valid SHALL be ignored outside RUN.
REQ-018 Latency from the last term accepted to done SHALL be 1 cycle plus the wait for sum_valid; sum_valid asserted in SUM SHALL give done=1 on the following edge.
REQ-019 Term arithmetic SHALL wrap modulo 2^16 with no overflow flag. Example: 3*23709+3 = 5594.

Reset
REQ-020 RST_N=0 SHALL asynchronously force the following, aborting any run:
- state=IDLE;
- busy=0, done=0, pass=0;
- err_count=0, first_err_idx=12'hFFF;
- exp=X0, exp_sum=0, idx=0.
REQ-021 After RST_N deasserts, the block SHALL remain in IDLE until start.

Structure
REQ-022 X0, A, B and the FSM state encoding SHALL live in a shared package lcg_pkg, also used by the LCG generator.
REQ-023 The next-term computation A*x+B mod 2^16 SHALL be a combinational sub-module lcg_step, reusable by the generator.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- N=3, terms 2633, 7902, 23709, sum_in=34244 -> done=1, pass=1, err_count=0, first_err_idx=FFF.
- N=4, fourth term 5594 (wrap), sum_in=39838 -> pass=1.
- N=3, second term 7903, sum_in=34244 -> pass=0, err_count=1, first_err_idx=1, third term 23709 still matches.
- N=3, correct terms, sum_in=34245 -> pass=0, err_count=0.
- N=3 with in_valid gaps of 0-5 cycles, plus sum_valid pulsed before SUM -> early sum_valid ignored, pass=1, three accepted terms.
- RST_N low mid-RUN after 1 term, then start with N=0 and sum_in=0 -> IDLE after reset, then pass=1 with done one cycle after sum_valid.
